block_stream_gen: RTL
=====================

# block_stream_gen

Character-stream generator emitting whitespace-separated `begin`/`end`/filler words one ASCII byte per transfer. It is the transmitting end of the block-matching character stream consumed by the BlockChecker. It converts a compact command interface into a byte stream while tracking nesting depth. It serves as a stimulus source for the checker and as an on-chip producer of well-formed, or deliberately malformed, block text.

## Interface
- `DEPTH_W`, default 4: nesting-depth counter width; maximum depth is 2^DEPTH_W−1.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd`  in  2  command: 0 BEGIN, 1 END, 2 FILLER, 3 FLUSH.
- `cmd_ready`  out  1  high only in IDLE.
- `out`  out  8  ASCII byte; 8'h00 when `out_valid` is 0.
- `out_valid`  out  1  byte present.
- `out_ready`  in  1  consumer accepts byte.
- `depth`  out  DEPTH_W  current open-block count.
- `balanced`  out  1  `depth`==0 and state IDLE.
- `err`  out  1  one-cycle pulse when a command is rejected.

## Operation
- Words emitted:
  - BEGIN → "begin " (6 bytes).
  - END → "end " (4 bytes).
  - FILLER → "x " (2 bytes).
  - Every word ends with 8'h20.
- Command accept: `cmd_valid && cmd_ready` at a rising edge.
- States:
  - IDLE:
    - BEGIN with `depth`<max: go to EMIT; `depth`+1 at acceptance.
    - END with `depth`>0: go to EMIT; `depth`−1 at acceptance.
    - FILLER: go to EMIT.
    - FLUSH with `depth`>0: go to FLUSH_EMIT.
    - BEGIN at max depth, END at depth 0, or FLUSH at depth 0: command consumed; `err`=1 for the next cycle except FLUSH at depth 0, which pulses nothing; stay in IDLE; no bytes emitted.
  - EMIT: index `idx` (0..5) walks the word.
    - Each `out_valid && out_ready` advances `idx`.
    - The handshake of the final byte returns to IDLE.
  - FLUSH_EMIT: repeatedly emits "end ".
    - `depth`−1 on each handshake of the trailing space.
    - Returns to IDLE on the handshake that takes `depth` to 0.
- `out` and `out_valid` are held stable while `out_ready`=0; there is no timeout.
- `out_valid` never drops mid-word.
- Letters are lowercase unless `BLOCK_GEN_MIXED_CASE_EN` is defined.
- Depth never wraps; saturation is handled by the rejection rule.
- Reset values: state IDLE, `idx` 0, `depth` 0, `out` 8'h00, `out_valid` 0, `cmd_ready` 1, `balanced` 1, `err` 0, case toggle 0.
- Reset mid-word abandons the partial word. Depth is cleared and nothing further is emitted.

## Timing
- Command accepted at edge N: `cmd_ready`=0 and first byte valid from edge N; `out` is registered.
- With `out_ready` held at 1, one byte per cycle; a 6-byte word occupies cycles N..N+5.
- `cmd_ready` returns to 1 the cycle after the final byte handshake.
- Minimum spacing between BEGIN acceptances is therefore 7 cycles.
- `err` pulses the cycle after the rejected acceptance; `cmd_ready` stays 1.
- `depth` is registered and updates the cycle after the qualifying edge.
- `cmd_valid` is ignored while `cmd_ready`=0; it is not queued.

## Configuration
- `BLOCK_GEN_MIXED_CASE_EN` defined:
  - A 1-bit toggle flips on every letter handshake, not on spaces.
  - Letters emitted while the toggle is 1 are uppercased (code − 8'h20).
  - The toggle persists across words and resets to 0.
  - Example: first BEGIN from reset yields "bEgIn ".
- Undefined: the toggle logic is absent; all letters are lowercase.

## Structure
- Package `block_gen_pkg`:
  - command encoding enum;
  - state enum (IDLE, EMIT, FLUSH_EMIT);
  - ASCII constants: space 8'h20, case offset 8'h20;
  - word lengths (6, 4, 2).
- Sub-module `block_word_rom`:
  - combinational;
  - inputs: word select and `idx`;
  - outputs: lowercase byte and `last` flag.
- The top level holds the FSM, counters, case toggle and output register.

## Test plan
- Reset, then BEGIN, FILLER, END with `out_ready`=1 → bytes "begin x end " back-to-back per word; `depth` 1→1→0; `balanced`=1 at the end.
- END at reset → `err`=1 for one cycle; no `out_valid`; `depth` stays 0.
- With `DEPTH_W`=2, four BEGINs → fourth gives `err`; `depth`=3; then FLUSH → "end end end "; `depth` 3→2→1→0.
- `out_ready` toggled 1,0,0,1 during "end " → `out` held at 8'h6E through the stall; no byte lost or duplicated.
- Reset asserted at the third byte of "begin " → `out_valid`=0, `depth`=0 immediately; the next BEGIN emits a full "begin ".
- `BLOCK_GEN_MIXED_CASE_EN` defined, BEGIN then END → "bEgIn " then "EnD "; the output stream is accepted by BlockChecker with result=1.

Source files
------------

// File: rtl/block_gen_pkg.sv
// block_gen_pkg: shared types and constants for the block stream generator.
//   cmd_e   - command encoding on the cmd input (BEGIN/END/FILLER/FLUSH)
//   state_e - generator FSM states
//   word_e  - word selector for block_word_rom
//   ASCII constants and word lengths, plus a helper giving the last index of a word.
package block_gen_pkg;

  typedef enum logic [1:0] {
    CmdBegin  = 2'd0,
    CmdEnd    = 2'd1,
    CmdFiller = 2'd2,
    CmdFlush  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StFlushEmit
  } state_e;

  typedef enum logic [1:0] {
    WordBegin,
    WordEnd,
    WordFiller
  } word_e;

  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] CaseOffset = 8'h20;

  localparam int unsigned LenBegin  = 6;
  localparam int unsigned LenEnd    = 4;
  localparam int unsigned LenFiller = 2;

  function automatic logic [2:0] word_last_idx(word_e w);
    case (w)
      WordBegin:  word_last_idx = 3'(LenBegin - 1);
      WordEnd:    word_last_idx = 3'(LenEnd - 1);
      WordFiller: word_last_idx = 3'(LenFiller - 1);
      default:    word_last_idx = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/block_word_rom.sv
// block_word_rom: combinational lookup of the lowercase text of each word.
//   word_i - word select (begin / end / filler)
//   idx_i  - byte index within the word
//   byte_o - lowercase ASCII byte at idx_i (space outside the word)
//   last_o - high when idx_i is the final (space) byte of the word
module block_word_rom
  import block_gen_pkg::*;
(
  input  word_e      word_i,
  input  logic [2:0] idx_i,
  output logic [7:0] byte_o,
  output logic       last_o
);

  always_comb begin
    byte_o = AsciiSpace;
    case (word_i)
      WordBegin: begin
        case (idx_i)
          3'd0:    byte_o = "b";
          3'd1:    byte_o = "e";
          3'd2:    byte_o = "g";
          3'd3:    byte_o = "i";
          3'd4:    byte_o = "n";
          default: byte_o = AsciiSpace;
        endcase
      end
      WordEnd: begin
        case (idx_i)
          3'd0:    byte_o = "e";
          3'd1:    byte_o = "n";
          3'd2:    byte_o = "d";
          default: byte_o = AsciiSpace;
        endcase
      end
      WordFiller: begin
        if (idx_i == 3'd0) byte_o = "x";
      end
      default: byte_o = AsciiSpace;
    endcase
    last_o = (idx_i == word_last_idx(word_i));
  end

endmodule

// File: rtl/block_stream_gen.sv
// block_stream_gen: turns BEGIN/END/FILLER/FLUSH commands into a space-separated
// "begin"/"end"/"x" ASCII byte stream while tracking block nesting depth.
//   clk, reset          - clock, asynchronous active-high reset
//   cmd_valid/cmd       - command offer; cmd_ready is high only while idle
//   out/out_valid       - registered output byte (8'h00 when not valid)
//   out_ready           - consumer accepts the presented byte
//   depth, balanced     - open-block count; balanced = idle with depth 0
//   err                 - one-cycle pulse after a rejected BEGIN/END
// Optional feature: define BLOCK_GEN_MIXED_CASE_EN to alternate letter case
// on every letter handshake ("bEgIn ").
module block_stream_gen
  import block_gen_pkg::*;
#(
  parameter int unsigned DEPTH_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic [1:0]         cmd,
  output logic               cmd_ready,
  output logic [7:0]         out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               balanced,
  output logic               err
);

  localparam logic [DEPTH_W-1:0] DepthMax = {DEPTH_W{1'b1}};
  localparam logic [DEPTH_W-1:0] DepthOne = {{(DEPTH_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  word_e              word_q, word_d;
  logic [2:0]         idx_q, idx_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [7:0]         out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
`ifdef BLOCK_GEN_MIXED_CASE_EN
  logic               toggle_q, toggle_d;
`endif

  word_e      rom_word;
  logic [2:0] rom_idx;
  logic [7:0] rom_byte;
  logic       rom_last;
  logic       load;
  logic       hs;

  // The ROM is addressed with the byte to be presented next, so out and last
  // are loaded together from a single lookup.
  block_word_rom u_rom (
    .word_i (rom_word),
    .idx_i  (rom_idx),
    .byte_o (rom_byte),
    .last_o (rom_last)
  );

  assign hs = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    depth_d     = depth_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    err_d       = 1'b0;
    rom_word    = word_q;
    rom_idx     = idx_q + 3'd1;
    load        = 1'b0;
`ifdef BLOCK_GEN_MIXED_CASE_EN
    toggle_d = toggle_q;
    if (hs && (out_q != AsciiSpace)) toggle_d = ~toggle_q;
`endif

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          case (cmd_e'(cmd))
            CmdBegin: begin
              if (depth_q != DepthMax) begin
                depth_d  = depth_q + DepthOne;
                word_d   = WordBegin;
                state_d  = StEmit;
                load     = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            CmdEnd: begin
              if (depth_q != '0) begin
                depth_d  = depth_q - DepthOne;
                word_d   = WordEnd;
                state_d  = StEmit;
                load     = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            CmdFiller: begin
              word_d  = WordFiller;
              state_d = StEmit;
              load    = 1'b1;
            end
            CmdFlush: begin
              // Flush at depth 0 is silently consumed.
              if (depth_q != '0) begin
                word_d  = WordEnd;
                state_d = StFlushEmit;
                load    = 1'b1;
              end
            end
            default: ;
          endcase
          if (load) begin
            rom_word = word_d;
            rom_idx  = 3'd0;
            idx_d    = 3'd0;
          end
        end
      end

      StEmit: begin
        if (hs) begin
          if (last_q) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
            out_d       = 8'h00;
            idx_d       = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
            load  = 1'b1;
          end
        end
      end

      StFlushEmit: begin
        if (hs) begin
          if (last_q) begin
            depth_d = depth_q - DepthOne;
            if (depth_q == DepthOne) begin
              state_d     = StIdle;
              out_valid_d = 1'b0;
              out_d       = 8'h00;
              idx_d       = 3'd0;
            end else begin
              // Restart "end " for the next still-open block.
              rom_idx = 3'd0;
              idx_d   = 3'd0;
              load    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            load  = 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      last_d      = rom_last;
      out_d       = rom_byte;
`ifdef BLOCK_GEN_MIXED_CASE_EN
      // Case follows the toggle value in force while the byte is presented.
      if (toggle_d && (rom_byte != AsciiSpace)) out_d = rom_byte - CaseOffset;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      word_q      <= WordBegin;
      idx_q       <= 3'd0;
      depth_q     <= '0;
      out_q       <= 8'h00;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef BLOCK_GEN_MIXED_CASE_EN
      toggle_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      depth_q     <= depth_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
      err_q       <= err_d;
`ifdef BLOCK_GEN_MIXED_CASE_EN
      toggle_q    <= toggle_d;
`endif
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign depth     = depth_q;
  assign balanced  = (state_q == StIdle) && (depth_q == '0);
  assign err       = err_q;

endmodule
